x_pattern_driver: RTL

- Upstream stimulus stage for the Mealy/Moore state machine: serialises a loaded bit pattern onto the single-bit X line that the FSM samples.
- One bit per DIV-clock slot, LSB first.
- Emits a one-cycle step strobe on the last clock of each slot so the downstream FSM can be clock-enabled or sampled at a known instant.
- Supports one-shot and repeating runs, a pause (hold), and a start/busy/done handshake.

---
 rtl/x_pattern_driver.sv | 130 +++++++++++++
 1 files changed

// File: rtl/x_pattern_driver.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : x_pattern_driver                                            |
// | Purpose  : Serialises a loaded pattern onto X, LSB first, one bit per  |
// |            DIV-clock slot, with step strobe and start/busy/done.       |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module x_pattern_driver #(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [3:0]       len,
   input  logic             repeat_en,
   input  logic             hold,
   output logic             X,
   output logic             x_valid,
   output logic             step,
   output logic             busy,
   output logic             done,
   output logic [3:0]       bit_cnt
);

   localparam logic [3:0]  c_PRESC_LAST = 4'(DIV - 1);
   localparam logic [4:0]  c_MAX_LEN    = 5'(WIDTH);
   localparam logic [31:0] c_WIDTH_U    = 32'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state,   w_state_nxt;
   logic [3:0]       r_presc,   w_presc_nxt;
   logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
   logic [WIDTH-1:0] r_shadow,  w_shadow_nxt;
   logic [4:0]       r_len_q,   w_len_q_nxt;
   logic             w_slot_end;
   logic             w_last_bit;
   logic             w_x;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_presc   <= 4'd0;
         r_bit_cnt <= 4'd0;
         r_shadow  <= '0;
         r_len_q   <= 5'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_presc   <= w_presc_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_shadow  <= w_shadow_nxt;
         r_len_q   <= w_len_q_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_presc_nxt   = r_presc;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shadow_nxt  = r_shadow;
      w_len_q_nxt   = r_len_q;
      w_slot_end    = (r_state == S_SHIFT) && (r_presc == c_PRESC_LAST) && !hold;
      w_last_bit    = ({1'b0, r_bit_cnt} == (r_len_q - 5'd1));

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_shadow_nxt = pattern;
               // Zero or over-long lengths send the whole register
               if (len == 4'd0 || {28'd0, len} > c_WIDTH_U)
                  w_len_q_nxt = c_MAX_LEN;
               else
                  w_len_q_nxt = {1'b0, len};
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            w_presc_nxt   = 4'd0;
            w_bit_cnt_nxt = 4'd0;
            w_state_nxt   = S_SHIFT;
         end
         S_SHIFT: begin
            if (!hold) begin
               if (w_slot_end) begin
                  w_presc_nxt = 4'd0;
                  if (w_last_bit) begin
                     w_bit_cnt_nxt = 4'd0;
                     if (!repeat_en)
                        w_state_nxt = S_DONE;
                  end else begin
                     w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                  end
               end else begin
                  w_presc_nxt = r_presc + 4'd1;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_x = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (r_bit_cnt == 4'(i))
            w_x = r_shadow[i];
      end
   end

   assign X       = (r_state == S_SHIFT) && w_x;
   assign x_valid = (r_state == S_SHIFT);
   assign step    = w_slot_end;
   assign busy    = (r_state == S_LOAD) || (r_state == S_SHIFT);
   assign done    = (r_state == S_DONE);
   assign bit_cnt = r_bit_cnt;

endmodule
`default_nettype wire
